// File: rtl/ip_tx_hdr_finalize_if.sv
// IPv4 header + payload bundle between the IP arbitration mux and IP TX.
// Handshake: a header or payload beat transfers on a rising clock edge where
// its valid and ready are both high; a source holds valid and data stable
// until that transfer, and ready may change freely.
interface ip_intf #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic                  ip_hdr_valid;
    logic                  ip_hdr_ready;
    logic [47:0]           eth_dest_mac;
    logic [47:0]           eth_src_mac;
    logic [15:0]           eth_type;
    logic [3:0]            ip_version;
    logic [3:0]            ip_ihl;
    logic [5:0]            ip_dscp;
    logic [1:0]            ip_ecn;
    logic [15:0]           ip_length;
    logic [15:0]           ip_identification;
    logic [2:0]            ip_flags;
    logic [12:0]           ip_fragment_offset;
    logic [7:0]            ip_ttl;
    logic [7:0]            ip_protocol;
    logic [15:0]           ip_header_checksum;
    logic [31:0]           ip_source_ip;
    logic [31:0]           ip_dest_ip;
    logic [DATA_WIDTH-1:0] ip_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0] ip_payload_axis_tkeep;
    logic                  ip_payload_axis_tvalid;
    logic                  ip_payload_axis_tready;
    logic                  ip_payload_axis_tlast;
    logic [ID_WIDTH-1:0]   ip_payload_axis_tid;
    logic [DEST_WIDTH-1:0] ip_payload_axis_tdest;
    logic [USER_WIDTH-1:0] ip_payload_axis_tuser;

    modport MASTER (
        output ip_hdr_valid, eth_dest_mac, eth_src_mac, eth_type, ip_version, ip_ihl,
               ip_dscp, ip_ecn, ip_length, ip_identification, ip_flags, ip_fragment_offset,
               ip_ttl, ip_protocol, ip_header_checksum, ip_source_ip, ip_dest_ip,
               ip_payload_axis_tdata, ip_payload_axis_tkeep, ip_payload_axis_tvalid,
               ip_payload_axis_tlast, ip_payload_axis_tid, ip_payload_axis_tdest,
               ip_payload_axis_tuser,
        input  ip_hdr_ready, ip_payload_axis_tready
    );

    modport SLAVE (
        input  ip_hdr_valid, eth_dest_mac, eth_src_mac, eth_type, ip_version, ip_ihl,
               ip_dscp, ip_ecn, ip_length, ip_identification, ip_flags, ip_fragment_offset,
               ip_ttl, ip_protocol, ip_header_checksum, ip_source_ip, ip_dest_ip,
               ip_payload_axis_tdata, ip_payload_axis_tkeep, ip_payload_axis_tvalid,
               ip_payload_axis_tlast, ip_payload_axis_tid, ip_payload_axis_tdest,
               ip_payload_axis_tuser,
        output ip_hdr_ready, ip_payload_axis_tready
    );
endinterface

// File: rtl/ip_tx_hdr_finalize.sv
// Outbound IPv4 header finalizer: forces version/IHL to 4/5, stamps a rolling
// identification number and recomputes the header checksum. The payload is a
// zero-latency passthrough gated so it stays behind its own header.
module ip_tx_hdr_finalize #(
    parameter int          DATA_WIDTH = 8,
    parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int          ID_WIDTH   = 8,
    parameter int          DEST_WIDTH = 8,
    parameter int          USER_WIDTH = 1,
    parameter logic [15:0] ID_INIT    = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    ip_intf.SLAVE       s_ip,
    ip_intf.MASTER      m_ip,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SUM     = 3'd1,
        FOLD    = 3'd2,
        HDR     = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    state_t      state, state_next;
    logic        hdr_accept, hdr_send;

    logic [47:0] dest_mac_r, src_mac_r;
    logic [15:0] eth_type_r;
    logic [3:0]  ver_r, ihl_r;
    logic [5:0]  dscp_r;
    logic [1:0]  ecn_r;
    logic [15:0] length_r, ident_r;
    logic [2:0]  flags_r;
    logic [12:0] frag_r;
    logic [7:0]  ttl_r, proto_r;
    logic [31:0] src_ip_r, dst_ip_r;
    logic [19:0] sum_r;
    logic [15:0] csum_r;
    logic [15:0] id_cnt;

    logic [19:0] sum_words;
    logic [16:0] fold_t;
    logic [15:0] fold_c;
    logic [BEAT_W-1:0] beat;

    assign hdr_accept = (state == IDLE) && s_ip.ip_hdr_valid;
    assign hdr_send   = (state == HDR) && m_ip.ip_hdr_ready;
    assign dbg_state  = state;

    // Ten header words summed wide enough that no carry is lost (10 * 0xFFFF < 2^20).
    assign sum_words = {4'd0, ver_r, ihl_r, dscp_r, ecn_r}
                     + {4'd0, length_r}
                     + {4'd0, ident_r}
                     + {4'd0, flags_r, frag_r}
                     + {4'd0, ttl_r, proto_r}
                     + {4'd0, src_ip_r[31:16]}
                     + {4'd0, src_ip_r[15:0]}
                     + {4'd0, dst_ip_r[31:16]}
                     + {4'd0, dst_ip_r[15:0]};

    // Two end-around-carry folds always reduce a 20-bit sum to 16 bits.
    assign fold_t = {1'b0, sum_r[15:0]} + {13'd0, sum_r[19:16]};
    assign fold_c = fold_t[15:0] + {15'd0, fold_t[16]};

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and handshake outputs; payload flows only in PAYLOAD.
    always_comb begin
        state_next                  = state;
        s_ip.ip_hdr_ready           = 1'b0;
        m_ip.ip_hdr_valid           = 1'b0;
        m_ip.ip_payload_axis_tvalid = 1'b0;
        s_ip.ip_payload_axis_tready = 1'b0;
        case (state)
            IDLE: begin
                s_ip.ip_hdr_ready = 1'b1;
                if (s_ip.ip_hdr_valid) state_next = SUM;
            end
            SUM:  state_next = FOLD;
            FOLD: state_next = HDR;
            HDR: begin
                m_ip.ip_hdr_valid = 1'b1;
                if (m_ip.ip_hdr_ready) state_next = PAYLOAD;
            end
            PAYLOAD: begin
                m_ip.ip_payload_axis_tvalid = s_ip.ip_payload_axis_tvalid;
                s_ip.ip_payload_axis_tready = m_ip.ip_payload_axis_tready;
                if (s_ip.ip_payload_axis_tvalid && m_ip.ip_payload_axis_tready &&
                    s_ip.ip_payload_axis_tlast)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the header with overrides, then run the two checksum stages.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dest_mac_r <= '0;
            src_mac_r  <= '0;
            eth_type_r <= '0;
            ver_r      <= '0;
            ihl_r      <= '0;
            dscp_r     <= '0;
            ecn_r      <= '0;
            length_r   <= '0;
            ident_r    <= '0;
            flags_r    <= '0;
            frag_r     <= '0;
            ttl_r      <= '0;
            proto_r    <= '0;
            src_ip_r   <= '0;
            dst_ip_r   <= '0;
            sum_r      <= '0;
            csum_r     <= '0;
        end else begin
            if (hdr_accept) begin
                dest_mac_r <= s_ip.eth_dest_mac;
                src_mac_r  <= s_ip.eth_src_mac;
                eth_type_r <= s_ip.eth_type;
                ver_r      <= 4'd4;
                ihl_r      <= 4'd5;
                dscp_r     <= s_ip.ip_dscp;
                ecn_r      <= s_ip.ip_ecn;
                length_r   <= s_ip.ip_length;
                ident_r    <= id_cnt;
                flags_r    <= s_ip.ip_flags;
                frag_r     <= s_ip.ip_fragment_offset;
                ttl_r      <= s_ip.ip_ttl;
                proto_r    <= s_ip.ip_protocol;
                src_ip_r   <= s_ip.ip_source_ip;
                dst_ip_r   <= s_ip.ip_dest_ip;
            end
            if (state == SUM)  sum_r  <= sum_words;
            if (state == FOLD) csum_r <= ~fold_c;
        end
    end

    // Identification advances only once a header has actually left.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         id_cnt <= ID_INIT;
        else if (hdr_send) id_cnt <= id_cnt + 16'd1;
    end

    assign m_ip.eth_dest_mac       = dest_mac_r;
    assign m_ip.eth_src_mac        = src_mac_r;
    assign m_ip.eth_type           = eth_type_r;
    assign m_ip.ip_version         = ver_r;
    assign m_ip.ip_ihl             = ihl_r;
    assign m_ip.ip_dscp            = dscp_r;
    assign m_ip.ip_ecn             = ecn_r;
    assign m_ip.ip_length          = length_r;
    assign m_ip.ip_identification  = ident_r;
    assign m_ip.ip_flags           = flags_r;
    assign m_ip.ip_fragment_offset = frag_r;
    assign m_ip.ip_ttl             = ttl_r;
    assign m_ip.ip_protocol        = proto_r;
    assign m_ip.ip_header_checksum = csum_r;
    assign m_ip.ip_source_ip       = src_ip_r;
    assign m_ip.ip_dest_ip         = dst_ip_r;

    // Payload content is wired straight through; only valid/ready are gated.
    assign beat = {s_ip.ip_payload_axis_tdata, s_ip.ip_payload_axis_tkeep,
                   s_ip.ip_payload_axis_tid, s_ip.ip_payload_axis_tdest,
                   s_ip.ip_payload_axis_tuser, s_ip.ip_payload_axis_tlast};
    assign {m_ip.ip_payload_axis_tdata, m_ip.ip_payload_axis_tkeep,
            m_ip.ip_payload_axis_tid, m_ip.ip_payload_axis_tdest,
            m_ip.ip_payload_axis_tuser, m_ip.ip_payload_axis_tlast} = beat;
endmodule

// File: tb/tb_ip_tx_hdr_finalize.sv
// Bench for ip_tx_hdr_finalize: two instances (ID_INIT 0 and 0xFFFF) share
// identical stimulus so identification wrap is observed alongside every test.
module tb_ip_tx_hdr_finalize;
    typedef struct packed {
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [15:0] etype;
        logic [3:0]  ver;
        logic [3:0]  ihl;
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] len;
        logic [15:0] ident;
        logic [2:0]  flags;
        logic [12:0] frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] csum;
        logic [31:0] src;
        logic [31:0] dst;
    } hdr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] st_a, st_b;
    int checks = 0;
    int failures = 0;
    logic [15:0] exp_id_a, exp_id_b;
    logic [26:0] exp_q[$];

    always #5 clk = ~clk;

    ip_intf s_a ();
    ip_intf m_a ();
    ip_intf s_b ();
    ip_intf m_b ();

    ip_tx_hdr_finalize #(.ID_INIT(16'h0000)) dut_a (
        .i_clk(clk), .i_rst(rst), .s_ip(s_a.SLAVE), .m_ip(m_a.MASTER), .dbg_state(st_a));
    ip_tx_hdr_finalize #(.ID_INIT(16'hFFFF)) dut_b (
        .i_clk(clk), .i_rst(rst), .s_ip(s_b.SLAVE), .m_ip(m_b.MASTER), .dbg_state(st_b));

    task automatic check(string tag, logic [271:0] obs, logic [271:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Internet checksum: one's-complement sum of the header words, folded until no carry remains.
    function automatic logic [15:0] ref_csum(hdr_t h, logic [15:0] id);
        int unsigned s;
        s = 32'h4500 + 32'(h.dscp) * 4 + 32'(h.ecn);
        s += 32'(h.len) + 32'(id) + 32'(h.flags) * 8192 + 32'(h.frag);
        s += 32'(h.ttl) * 256 + 32'(h.proto);
        s += (h.src >> 16) + (h.src & 32'hFFFF) + (h.dst >> 16) + (h.dst & 32'hFFFF);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic hdr_t finalize(hdr_t h, logic [15:0] id);
        hdr_t e;
        e = h;
        e.ver = 4'd4;
        e.ihl = 4'd5;
        e.ident = id;
        e.csum = ref_csum(h, id);
        return e;
    endfunction

    function automatic hdr_t rand_hdr();
        hdr_t h;
        h.dmac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        h.smac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        h.etype = 16'($urandom);
        h.ver = 4'($urandom);
        h.ihl = 4'($urandom);
        h.dscp = 6'($urandom);
        h.ecn = 2'($urandom);
        h.len = 16'($urandom);
        h.ident = 16'($urandom);
        h.flags = 3'($urandom);
        h.frag = 13'($urandom);
        h.ttl = 8'($urandom);
        h.proto = 8'($urandom);
        h.csum = 16'($urandom);
        h.src = $urandom;
        h.dst = $urandom;
        return h;
    endfunction

    function automatic hdr_t obs_hdr(bit sel_b);
        hdr_t o;
        if (!sel_b) begin
            o.dmac = m_a.eth_dest_mac;  o.smac = m_a.eth_src_mac;  o.etype = m_a.eth_type;
            o.ver = m_a.ip_version;     o.ihl = m_a.ip_ihl;        o.dscp = m_a.ip_dscp;
            o.ecn = m_a.ip_ecn;         o.len = m_a.ip_length;     o.ident = m_a.ip_identification;
            o.flags = m_a.ip_flags;     o.frag = m_a.ip_fragment_offset;
            o.ttl = m_a.ip_ttl;         o.proto = m_a.ip_protocol; o.csum = m_a.ip_header_checksum;
            o.src = m_a.ip_source_ip;   o.dst = m_a.ip_dest_ip;
        end else begin
            o.dmac = m_b.eth_dest_mac;  o.smac = m_b.eth_src_mac;  o.etype = m_b.eth_type;
            o.ver = m_b.ip_version;     o.ihl = m_b.ip_ihl;        o.dscp = m_b.ip_dscp;
            o.ecn = m_b.ip_ecn;         o.len = m_b.ip_length;     o.ident = m_b.ip_identification;
            o.flags = m_b.ip_flags;     o.frag = m_b.ip_fragment_offset;
            o.ttl = m_b.ip_ttl;         o.proto = m_b.ip_protocol; o.csum = m_b.ip_header_checksum;
            o.src = m_b.ip_source_ip;   o.dst = m_b.ip_dest_ip;
        end
        return o;
    endfunction

    // Beat layout: [7:0] data, [8] keep, [9] last, [10] user, [18:11] dest, [26:19] id.
    function automatic logic [26:0] obs_beat();
        return {m_a.ip_payload_axis_tid, m_a.ip_payload_axis_tdest, m_a.ip_payload_axis_tuser,
                m_a.ip_payload_axis_tlast, m_a.ip_payload_axis_tkeep, m_a.ip_payload_axis_tdata};
    endfunction

    task automatic drive_hdr(hdr_t h, logic v);
        s_a.ip_hdr_valid = v;           s_b.ip_hdr_valid = v;
        s_a.eth_dest_mac = h.dmac;      s_b.eth_dest_mac = h.dmac;
        s_a.eth_src_mac = h.smac;       s_b.eth_src_mac = h.smac;
        s_a.eth_type = h.etype;         s_b.eth_type = h.etype;
        s_a.ip_version = h.ver;         s_b.ip_version = h.ver;
        s_a.ip_ihl = h.ihl;             s_b.ip_ihl = h.ihl;
        s_a.ip_dscp = h.dscp;           s_b.ip_dscp = h.dscp;
        s_a.ip_ecn = h.ecn;             s_b.ip_ecn = h.ecn;
        s_a.ip_length = h.len;          s_b.ip_length = h.len;
        s_a.ip_identification = h.ident; s_b.ip_identification = h.ident;
        s_a.ip_flags = h.flags;         s_b.ip_flags = h.flags;
        s_a.ip_fragment_offset = h.frag; s_b.ip_fragment_offset = h.frag;
        s_a.ip_ttl = h.ttl;             s_b.ip_ttl = h.ttl;
        s_a.ip_protocol = h.proto;      s_b.ip_protocol = h.proto;
        s_a.ip_header_checksum = h.csum; s_b.ip_header_checksum = h.csum;
        s_a.ip_source_ip = h.src;       s_b.ip_source_ip = h.src;
        s_a.ip_dest_ip = h.dst;         s_b.ip_dest_ip = h.dst;
    endtask

    task automatic drive_beat(logic v, logic [26:0] b);
        s_a.ip_payload_axis_tvalid = v;        s_b.ip_payload_axis_tvalid = v;
        s_a.ip_payload_axis_tdata = b[7:0];    s_b.ip_payload_axis_tdata = b[7:0];
        s_a.ip_payload_axis_tkeep = b[8];      s_b.ip_payload_axis_tkeep = b[8];
        s_a.ip_payload_axis_tlast = b[9];      s_b.ip_payload_axis_tlast = b[9];
        s_a.ip_payload_axis_tuser = b[10];     s_b.ip_payload_axis_tuser = b[10];
        s_a.ip_payload_axis_tdest = b[18:11];  s_b.ip_payload_axis_tdest = b[18:11];
        s_a.ip_payload_axis_tid = b[26:19];    s_b.ip_payload_axis_tid = b[26:19];
    endtask

    task automatic set_ready(logic hdr_rdy, logic t_rdy);
        m_a.ip_hdr_ready = hdr_rdy;            m_b.ip_hdr_ready = hdr_rdy;
        m_a.ip_payload_axis_tready = t_rdy;    m_b.ip_payload_axis_tready = t_rdy;
    endtask

    // Present a header from a falling edge and wait for it to be taken.
    task automatic send_hdr(hdr_t h);
        int n;
        logic acc;
        @(negedge clk);
        drive_hdr(h, 1'b1);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            #1 acc = s_a.ip_hdr_ready;
            @(negedge clk);
            n++;
        end
        drive_hdr(h, 1'b0);
        check("hdr_accept", acc, 1'b1);
    endtask

    // Entered one cycle after acceptance; checks latency, hold behaviour and fields.
    task automatic expect_hdr(hdr_t h, int hold, logic gold_en, logic [15:0] gold);
        hdr_t ea, eb;
        int lat;
        logic t_rdy;
        ea = finalize(h, exp_id_a);
        eb = finalize(h, exp_id_b);
        t_rdy = m_a.ip_payload_axis_tready;
        check("hdr_ready_low_after_accept", s_a.ip_hdr_ready, 1'b0);
        lat = 1;
        while (!m_a.ip_hdr_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("hdr_latency", lat, 3);
        for (int i = 0; i < hold; i++) begin
            #1;
            check("hold_fields", obs_hdr(1'b0), ea);
            check("hold_handshakes", {m_a.ip_hdr_valid, s_a.ip_hdr_ready,
                  s_a.ip_payload_axis_tready, m_a.ip_payload_axis_tvalid}, 4'b1000);
            @(negedge clk);
        end
        set_ready(1'b1, t_rdy);
        #1;
        check("hdr_valid", {m_a.ip_hdr_valid, m_b.ip_hdr_valid}, 2'b11);
        check("hdr_fields_a", obs_hdr(1'b0), ea);
        check("hdr_fields_b", obs_hdr(1'b1), eb);
        if (gold_en) check("hdr_golden_csum", m_a.ip_header_checksum, gold);
        @(negedge clk);
        set_ready(1'b0, t_rdy);
        exp_id_a = exp_id_a + 16'd1;
        exp_id_b = exp_id_b + 16'd1;
    endtask

    // Stream n beats; optional random stalls on both sides; optional reset at a beat index.
    task automatic send_payload(int n, bit rnd, int rst_at);
        int idx, got, cyc;
        logic sv;
        logic [26:0] beats[$];
        logic [26:0] b;
        beats.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b = 27'($urandom);
            b[9] = (i == n - 1);
            beats.push_back(b);
            exp_q.push_back(b);
        end
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 2000) begin
            sv = (idx < n) && (!rnd || $urandom_range(0, 3) != 0);
            drive_beat(sv, beats[(idx < n) ? idx : n - 1]);
            set_ready(1'b0, !rnd || $urandom_range(0, 2) != 0);
            if (rst_at >= 0 && idx == rst_at) begin
                rst = 1'b1;
                #1;
                check("reset_mid_payload_a", {m_a.ip_hdr_valid, m_a.ip_payload_axis_tvalid,
                      s_a.ip_payload_axis_tready, s_a.ip_hdr_ready, st_a}, {4'b0001, 3'd0});
                check("reset_mid_payload_b", {m_b.ip_payload_axis_tvalid, st_b}, {1'b0, 3'd0});
                @(negedge clk);
                rst = 1'b0;
                drive_beat(1'b0, '0);
                exp_id_a = 16'h0000;
                exp_id_b = 16'hFFFF;
                exp_q.delete();
                return;
            end
            #1;
            if (m_a.ip_payload_axis_tvalid && m_a.ip_payload_axis_tready) begin
                check("payload_beat", obs_beat(), exp_q.pop_front());
                got++;
            end
            if (s_a.ip_payload_axis_tvalid && s_a.ip_payload_axis_tready) idx++;
            @(negedge clk);
            cyc++;
        end
        drive_beat(1'b0, '0);
        #1;
        check("payload_beat_count", got, n);
        check("idle_after_tlast", {st_a, s_a.ip_hdr_ready, st_b}, {3'd0, 1'b1, 3'd0});
    endtask

    initial begin
        hdr_t hg, h;
        drive_hdr('0, 1'b0);
        drive_beat(1'b1, 27'h155);
        set_ready(1'b0, 1'b1);
        exp_id_a = 16'h0000;
        exp_id_b = 16'hFFFF;
        repeat (3) @(negedge clk);
        #1;
        check("reset_handshakes", {st_a, s_a.ip_hdr_ready, m_a.ip_hdr_valid,
              m_a.ip_payload_axis_tvalid, s_a.ip_payload_axis_tready}, {3'd0, 4'b1000});
        check("reset_hdr_fields", obs_hdr(1'b0), '0);
        @(negedge clk);
        rst = 1'b0;
        drive_beat(1'b0, '0);

        // Golden header, three back-to-back single-beat packets (ids 0,1,2 / FFFF,0,1).
        hg = rand_hdr();
        hg.ver = 4'd6;  hg.ihl = 4'hF;  hg.dscp = 6'd0;  hg.ecn = 2'd0;
        hg.len = 16'h0073;  hg.ident = 16'h1234;  hg.flags = 3'b010;  hg.frag = 13'd0;
        hg.ttl = 8'h40;  hg.proto = 8'h11;  hg.csum = 16'hFFFF;
        hg.src = 32'hC0A8_0001;  hg.dst = 32'hC0A8_00C7;
        send_hdr(hg); expect_hdr(hg, 0, 1'b1, 16'hB861); send_payload(1, 1'b0, -1);
        send_hdr(hg); expect_hdr(hg, 0, 1'b1, 16'hB860); send_payload(1, 1'b0, -1);
        send_hdr(hg); expect_hdr(hg, 0, 1'b1, 16'hB85F); send_payload(1, 1'b0, -1);

        // Header backpressure with a payload beat offered early.
        h = rand_hdr();
        send_hdr(h);
        drive_beat(1'b1, 27'h2AA);
        set_ready(1'b0, 1'b1);
        expect_hdr(h, 10, 1'b0, 16'h0);
        send_payload(4, 1'b0, -1);

        // Long payload with random stalls on both sides.
        h = rand_hdr();
        send_hdr(h); expect_hdr(h, 0, 1'b0, 16'h0); send_payload(64, 1'b1, -1);

        // Reset during a 20-beat payload, then a clean packet restarts the ids.
        h = rand_hdr();
        send_hdr(h); expect_hdr(h, 0, 1'b0, 16'h0); send_payload(20, 1'b0, 5);
        h = rand_hdr();
        send_hdr(h); expect_hdr(h, 0, 1'b0, 16'h0); send_payload(3, 1'b1, -1);

        // Random packets of varied length and header backpressure.
        for (int p = 0; p < 4; p++) begin
            h = rand_hdr();
            send_hdr(h);
            expect_hdr(h, $urandom_range(0, 3), 1'b0, 16'h0);
            send_payload($urandom_range(1, 8), 1'b1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ip_tx_hdr_finalize.md
# ip_tx_hdr_finalize

Finalizes outbound IPv4 headers directly downstream of the IP arbitration mux and before the IP-to-Ethernet transmit stage. Per packet it:
- forces version/IHL to 4/5;
- stamps a rolling 16-bit identification number;
- computes the header checksum over the final header fields.

The payload stream passes through unmodified and stays aligned to its header. One packet is in flight at a time.

## Interface
Parameters:
- DATA_WIDTH, 8: payload tdata width
- KEEP_WIDTH, DATA_WIDTH/8: payload tkeep width
- ID_WIDTH / DEST_WIDTH / USER_WIDTH, 8 / 8 / 1: sideband widths, passed through
- ID_INIT, 16'h0000: identification counter value after reset

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- s_ip  ip_intf.SLAVE  bundle  input header and payload, fed from the arbitration mux master side
- m_ip  ip_intf.MASTER  bundle  finalized header and payload, to IP TX
- Bundle fields used:
  - header: ip_hdr_valid/ready, eth_dest_mac[48], eth_src_mac[48], eth_type[16], ip_version[4], ip_ihl[4], ip_dscp[6], ip_ecn[2], ip_length[16], ip_identification[16], ip_flags[3], ip_fragment_offset[13], ip_ttl[8], ip_protocol[8], ip_header_checksum[16], ip_source_ip[32], ip_dest_ip[32]
  - payload: ip_payload_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser

## Operation
- FSM states: IDLE, SUM, FOLD, HDR, PAYLOAD.
- IDLE:
  - s_ip.ip_hdr_ready=1.
  - On s hdr handshake, register all header fields, then go to SUM.
  - The registered header is overridden as follows: version=4, ihl=5, identification=id_cnt. Incoming identification and checksum are ignored.
- SUM:
  - Sum ten 16-bit words into a 20-bit accumulator: {ver,ihl,dscp,ecn}, length, identification, {flags,frag_off}, {ttl,protocol}, 16'h0, src[31:16], src[15:0], dst[31:16], dst[15:0].
  - Go to FOLD.
- FOLD:
  - t = sum[15:0] + sum[19:16]; c = t[15:0] + t[16]; checksum = ~c[15:0].
  - Go to HDR.
- HDR:
  - m_ip.ip_hdr_valid=1 with the registered and overridden fields plus the computed checksum. Outputs hold stable until m hdr_ready.
  - On the m handshake: id_cnt increments (16-bit wrap 0xFFFF -> 0x0000), then go to PAYLOAD.
- PAYLOAD:
  - Combinational passthrough:
    - m tvalid = s tvalid
    - s tready = m tready
    - tdata/tkeep/tlast/tid/tdest/tuser pass straight through
  - On a beat with tvalid & tready & tlast, go to IDLE.
- Outside PAYLOAD: s tready=0 and m tvalid=0. A payload offered early stalls and is not dropped.
- eth_* fields, dscp, ecn, length, flags, fragment_offset, ttl, protocol, src and dst pass unchanged.

## Timing
- Reset values:
  - state=IDLE, id_cnt=ID_INIT
  - m hdr_valid=0, m tvalid=0, s tready=0, s hdr_ready=1 (IDLE)
  - registered header fields = 0
- Header latency: s hdr handshake in cycle T -> m hdr_valid high in T+3 (T+1 SUM, T+2 FOLD, T+3 HDR).
- s hdr_ready is low from T+1 until the cycle after the final tlast beat. This gives a minimum one-cycle IDLE bubble between packets.
- Payload adds zero latency and no buffering. Throughput is 1 beat/cycle while both sides are ready.
- Backpressure on m hdr_ready holds HDR indefinitely; fields and checksum do not change while held.
- A single-beat packet (first beat has tlast) returns to IDLE after that beat.
- A reset asserted mid-packet returns immediately to reset values; the partial packet is abandoned. id_cnt is not incremented for a header that never completed its m handshake.

## Test plan
- Checksum golden:
  - Stimulus: dscp/ecn 0, length 0x0073, flags 3'b010, frag 0, ttl 0x40, proto 0x11, src 0xC0A80001, dst 0xC0A800C7, ID_INIT 0, input checksum 0xFFFF.
  - Required: m header has id 0x0000, checksum 0xB861, version 4, ihl 5, and m hdr_valid exactly 3 cycles after accept.
- Identification sequence: 3 back-to-back 1-beat packets -> ids 0,1,2, and checksums differ from the golden by exactly the id delta (0xB861, 0xB860, 0xB85F).
- Wrap: ID_INIT=16'hFFFF, 2 packets -> ids 0xFFFF then 0x0000.
- Header backpressure:
  - Stimulus: hold m hdr_ready=0 for 10 cycles.
  - Required: fields stable, s tready=0, s hdr_ready=0, no payload beats move; the first payload beat is accepted only after the m handshake.
- Payload passthrough: 64-beat payload with random m tready and s tvalid -> bytes, tlast, and tuser identical and in order; return to IDLE the cycle after the tlast beat.
- Reset mid-payload: assert i_rst at beat 5 of 20 -> all valids low and state IDLE in the same cycle; the next packet gets id ID_INIT and is correctly formed.
